// File: rtl/adder_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_uart_pkg : FSM state encoding and ASCII codes for the result   |
// |                  UART transmitter                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP_BIT  = 3'd3,
    ST_NEXT      = 3'd4
  } tx_state_t;

  localparam logic [7:0] C_ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] C_ASCII_MINUS = 8'h2D;
  localparam logic [7:0] C_ASCII_ZERO  = 8'h30;
  localparam logic [7:0] C_ASCII_CR    = 8'h0D;
  localparam logic [7:0] C_ASCII_LF    = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_byte : 8N1 byte serializer with load/ready handshake         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_byte
  import adder_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_txd
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t       r_state, w_state_nxt;
  logic [BW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_txd, w_txd_nxt;
  logic            w_baud_end;

  assign w_baud_end = (r_baud == C_BAUD_LAST);
  // Ready during the last stop-bit cycle so bytes chain back-to-back.
  assign o_ready    = (r_state == ST_IDLE) || ((r_state == ST_STOP_BIT) && w_baud_end);
  assign o_txd      = r_txd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_txd_nxt  = 1'b1;
      end
      ST_START_BIT: begin
        if (w_baud_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP_BIT;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      ST_STOP_BIT: begin
        if (w_baud_end) begin
          w_state_nxt = ST_IDLE;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_baud_nxt  = '0;
        w_txd_nxt   = 1'b1;
      end
    endcase
    if (i_load && o_ready) begin
      w_state_nxt = ST_START_BIT;
      w_baud_nxt  = '0;
      w_shift_nxt = i_data;
      w_txd_nxt   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | result_uart_tx : sends an (N+1)-digit signed-digit result as ASCII   |
// |                  over UART; RESULT_UART_CTS_EN adds cts_n gating     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module result_uart_tx
  import adder_uart_pkg::*;
#(
  parameter int N            = 6,
  parameter int C            = 3,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [(N+1)*C-1:0] result,
  input  logic             cts_n,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam int W      = (N + 1) * C;
  localparam int NBYTES = 2 * (N + 1) + 2;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NBYTES - 1);

  tx_state_t       r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [W-1:0]    r_frame, w_frame_nxt;
  logic [W-1:0]    w_src;
  logic [7:0]      w_byte;
  logic            w_load;
  logic            w_ready;
  logic            w_cts_ok;

`ifdef RESULT_UART_CTS_EN
  assign w_cts_ok = ~cts_n;
`else
  logic w_unused_cts;
  assign w_unused_cts = cts_n;
  assign w_cts_ok     = 1'b1;
`endif

  // Magnitude is formed at C+1 bits so the most negative digit is representable.
  function automatic logic [7:0] frame_byte(input logic [W-1:0] f, input logic [IW-1:0] idx);
    logic [C-1:0] d;
    logic [C:0]   ext;
    logic [C:0]   mag;
    int           dig;
    d   = '0;
    dig = N - int'(idx >> 1);
    for (int k = 0; k <= N; k++) begin
      if (k == dig) d = f[k*C +: C];
    end
    ext = {d[C-1], d};
    mag = d[C-1] ? (~ext + (C+1)'(1)) : ext;
    if (idx >= IW'(2 * (N + 1)))
      frame_byte = idx[0] ? C_ASCII_LF : C_ASCII_CR;
    else if (!idx[0])
      frame_byte = d[C-1] ? C_ASCII_MINUS : C_ASCII_PLUS;
    else
      frame_byte = C_ASCII_ZERO + 8'(mag);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    w_load      = 1'b0;
    // The first byte leaves in the accepting cycle, before r_frame is loaded.
    w_src       = (r_state == ST_IDLE) ? result : r_frame;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_frame_nxt = result;
          w_load      = w_cts_ok;
          w_state_nxt = w_cts_ok ? ST_DATA : ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (w_cts_ok) begin
          w_load      = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_ready) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = ST_NEXT;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_load      = w_cts_ok;
            w_state_nxt = w_cts_ok ? ST_DATA : ST_START_BIT;
          end
        end
      end
      ST_NEXT: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    w_byte = frame_byte(w_src, w_idx_nxt);
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_NEXT);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_load),
    .i_data (w_byte),
    .o_ready(w_ready),
    .o_txd  (txd)
  );

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_result_uart_tx : directed self-checking bench for result_uart_tx  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_result_uart_tx;

  localparam int N   = 6;
  localparam int C   = 3;
  localparam int CPB = 4;
  localparam logic [20:0] PAT_B = {3'b100, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
  localparam logic [20:0] PAT_C = {3'b010, 3'b000, 3'b101, 3'b110, 3'b001, 3'b111, 3'b011};

  logic        clk;
  logic        reset;
  logic        start;
  logic [20:0] result;
  logic        cts_n;
  logic        txd;
  logic        busy;
  logic        done;

  int          n_checks;
  int          n_errors;
  int          cyc;
  int          fall_cyc;
  int          done_cnt;
  logic [7:0]  rx_q[$];
  string       s_zero, s_b, s_c;

  result_uart_tx #(
    .N(N),
    .C(C),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .result(result),
    .cts_n (cts_n),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected frame completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; decodes 16 contiguous 8N1 bytes sampled mid-bit.
  task automatic rx_frame(input string tag);
    int         to;
    int         ferr;
    logic [7:0] data;
    rx_q.delete();
    ferr = 0;
    to   = 0;
    while (txd !== 1'b0 && to < 200) begin
      @(negedge clk);
      to++;
    end
    check({tag, "_rx_timeout"}, (to >= 200), 0);
    fall_cyc = cyc;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      if (txd !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        data[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      if (txd !== 1'b1) ferr++;
      rx_q.push_back(data);
      if (b < 15) begin
        repeat (CPB - 1) @(negedge clk);
        if (txd !== 1'b0) ferr++;
      end
    end
    check({tag, "_framing"}, ferr, 0);
  endtask

  task automatic check_frame(input string tag, input string exp);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
  endtask

  task automatic finish_frame(input string tag, input bit poke);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_done_lat"}, cyc - fall_cyc, 640);
    check({tag, "_busy_at_done"}, busy, 1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_clr"}, busy, 0);
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    s_zero = "+0+0+0+0+0+0+0";
    s_zero = {s_zero, "\015\012"};
    s_b    = "-4+3-1+0+0+0+1";
    s_b    = {s_b, "\015\012"};
    s_c    = "+2+0-3-2+1-1+3";
    s_c    = {s_c, "\015\012"};

    reset  = 1'b1;
    start  = 1'b0;
    result = '0;
    cts_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Frame of zeros, started on the first edge after reset release.
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    check("f1_lat_txd", txd, 0);
    check("f1_lat_busy", busy, 1);
    rx_frame("f1");
    check_frame("f1", s_zero);
    finish_frame("f1", 1'b0);

    // Mixed digits; a second start with new data mid-frame must be ignored,
    // as must a start coinciding with done.
    repeat (2) @(negedge clk);
    result = PAT_B;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    fork
      rx_frame("f2");
      begin
        repeat (50) @(negedge clk);
        result = PAT_C;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_frame("f2", s_b);
    finish_frame("f2", 1'b1);
    repeat (5) @(negedge clk);
    check("f2_no_restart_busy", busy, 0);
    check("f2_no_restart_txd", txd, 1);

    // Reset asserted 10 cycles into byte 3 (a '0' data bit is on the line).
    result = PAT_C;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("f3_lat_txd", txd, 0);
    repeat (130) @(negedge clk);
    check("f3_mid_txd", txd, 0);
    reset = 1'b1;
    #1;
    check("f3_rst_txd", txd, 1);
    check("f3_rst_busy", busy, 0);
    check("f3_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("f3_post_busy", busy, 0);

    // Fresh complete frame after the reset.
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    check("f4_lat_busy", busy, 1);
    rx_frame("f4");
    check_frame("f4", s_c);
    finish_frame("f4", 1'b0);

`ifdef RESULT_UART_CTS_EN
    // Host holds off: line stays idle while busy until cts_n falls.
    cts_n  = 1'b1;
    result = PAT_B;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    check("f5_hold_txd", txd, 1);
    check("f5_hold_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("f5_hold_txd_late", txd, 1);
    cts_n = 1'b0;
    @(negedge clk);
    check("f5_go_txd", txd, 0);
    rx_frame("f5");
    check_frame("f5", s_b);
    finish_frame("f5", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter N, default 6: number of input operand digits; the result carries N+1 digits.
REQ-002 Parameter C, default 3: bits per signed two's-complement digit; legal range 2..4.
REQ-003 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (115200 baud at 50 MHz); minimum 2.
REQ-004 clk  input  1: the single clock; all logic samples on posedge clk.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: single-cycle request to transmit result.
REQ-007 result  input  (N+1)*C: digit vector; digit k occupies bits [k*C +: C], and digit N is the most significant.
REQ-008 cts_n  input  1: host clear-to-send, active low.
REQ-009 txd  output  1: UART serial line, 8N1 format, idle high.
REQ-010 busy  output  1: high from the cycle after start is accepted until done.
REQ-011 done  output  1: one-cycle pulse when the frame completes.

Function
REQ-012 start SHALL be accepted only when busy=0; acceptance latches result into an internal frame register.
REQ-013 The block SHALL ignore start while busy=1, and SHALL NOT re-latch result.
REQ-014 Frame: digits N down to 0, two bytes each, then CR (0x0D) and LF (0x0A); 2*(N+1)+2 bytes total (16 at defaults).
REQ-015 First byte of each digit: '+' (0x2B) if the digit MSB is 0, otherwise '-' (0x2D).
REQ-016 Second byte of each digit: 0x30 + |d|, with |d| computed at C+1 bits so that the most negative digit encodes correctly (C=3: 3'b100 -> '4').
REQ-017 Each byte: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles; no idle gap between bytes unless CTS gating applies.
REQ-018 Latency: start accepted at edge k -> busy=1 and txd=0 (first start bit) from edge k+1.
REQ-019 FSM states: IDLE, START_BIT, DATA (3-bit bit index), STOP_BIT, NEXT.
REQ-020 IDLE -> START_BIT on accepted start.
REQ-021 START_BIT -> DATA after CLKS_PER_BIT cycles.
REQ-022 DATA -> STOP_BIT after bit 7 completes.
REQ-023 STOP_BIT -> NEXT after CLKS_PER_BIT cycles.
REQ-024 NEXT -> START_BIT if bytes remain; otherwise -> IDLE with done=1 for exactly that cycle and busy=0 from the following cycle.
REQ-025 A byte counter SHALL select the byte; it wraps to 0 only via IDLE, never mid-frame.
REQ-026 If start arrives in the same cycle done pulses, it SHALL be ignored; start is accepted one cycle later at the earliest.

Reset
REQ-027 While reset is high: txd=1, busy=0, done=0, state=IDLE, counters=0, frame register=0.
REQ-028 Assertion of reset mid-byte SHALL drive txd high immediately, without completing the byte.
REQ-029 The first start is accepted on the first posedge after reset deasserts.

Configuration
REQ-030 Macro RESULT_UART_CTS_EN: when defined, NEXT (and the first START_BIT) SHALL wait with txd=1 while cts_n=1, and SHALL proceed on the first cycle cts_n=0; bytes already started are never paused.
REQ-031 Without RESULT_UART_CTS_EN, cts_n SHALL be ignored and left unconnected internally.

Structure
REQ-032 Shared package adder_uart_pkg SHALL hold the FSM state enum and the ASCII constants (0x2B, 0x2D, 0x30, 0x0D, 0x0A).
REQ-033 The byte serializer (baud counter, START/DATA/STOP shifting) SHALL be sub-module uart_tx_byte with a load/ready handshake; result_uart_tx owns the frame sequencing and digit encoding.

Verification (N=6, C=3, CLKS_PER_BIT=4)
REQ-034 result=0, start pulse -> txd decodes "+0+0+0+0+0+0+0\r\n"; done pulses once 16*10*4=640 cycles after txd falls.
REQ-035 result digits (MSD..LSD) = 3'b100,3'b011,3'b111,0,0,0,3'b001 -> "-4+3-1+0+0+0+1\r\n".
REQ-036 Second start pulse 50 cycles into the frame -> identical frame, exactly one done pulse, no re-latch of changed result.
REQ-037 reset pulsed 10 cycles into byte 3 -> txd=1 same cycle, busy=0; a new start then sends a complete fresh frame.
REQ-038 With RESULT_UART_CTS_EN defined: cts_n=1 at start -> txd stays 1 and busy=1; cts_n driven 0 -> start bit begins on the next edge.
